pll_drp_writer: RTL and testbench



---
 rtl/pll_drp_pkg.sv | 55 +++++
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_drp_writer.sv | 190 +++++++++++++++++++
 tb/tb_pll_drp_writer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLLE2 DRP read-modify-write writer.
package pll_drp_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ERR_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_RD,
        WRITE,
        WAIT_WR,
        NEXT,
        RELEASE,
        WAIT_LOCK
    } state_t;

    // Latched register update request
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
        logic              last;
    } drp_req_t;

    localparam logic [ERR_W-1:0] ERR_NONE = 2'd0;
    localparam logic [ERR_W-1:0] ERR_DRDY = 2'd1;
    localparam logic [ERR_W-1:0] ERR_LOCK = 2'd2;

    // PLLE2_ADV DRP register map
    localparam logic [ADDR_W-1:0] CLKOUT0_REG1  = 7'h08;
    localparam logic [ADDR_W-1:0] CLKOUT0_REG2  = 7'h09;
    localparam logic [ADDR_W-1:0] CLKOUT1_REG1  = 7'h0A;
    localparam logic [ADDR_W-1:0] CLKOUT1_REG2  = 7'h0B;
    localparam logic [ADDR_W-1:0] CLKFBOUT_REG1 = 7'h14;
    localparam logic [ADDR_W-1:0] CLKFBOUT_REG2 = 7'h15;
    localparam logic [ADDR_W-1:0] DIVCLK        = 7'h16;
    localparam logic [ADDR_W-1:0] LOCK1         = 7'h18;
    localparam logic [ADDR_W-1:0] LOCK2         = 7'h19;
    localparam logic [ADDR_W-1:0] LOCK3         = 7'h1A;
    localparam logic [ADDR_W-1:0] FILT1         = 7'h4E;
    localparam logic [ADDR_W-1:0] FILT2         = 7'h4F;
    localparam logic [ADDR_W-1:0] POWER         = 7'h28;

    // Mask bit 1 keeps the old register bit, 0 takes the new one
    function automatic logic [DATA_W-1:0] drp_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [DATA_W-1:0] mask
    );
        return (old_val & mask) | (new_val & ~mask);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    // Shift the asynchronous input through two flops
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/pll_drp_writer.sv
// DRP initiator: batched read-modify-write of PLLE2 registers with PLL reset and re-lock supervision.
module pll_drp_writer
    import pll_drp_pkg::*;
#(
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_BLANK   = 4
) (
    input  logic              clk100,
    input  logic              cpu_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [DATA_W-1:0] req_mask,
    input  logic              req_last,
    output logic [ADDR_W-1:0] drp_daddr,
    output logic [DATA_W-1:0] drp_di,
    output logic              drp_den,
    output logic              drp_dwe,
    input  logic [DATA_W-1:0] drp_do,
    input  logic              drp_drdy,
    input  logic              pll_locked,
    output logic              pll_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ERR_W-1:0]  err_code
);

    localparam int unsigned DCNT_W = $clog2(DRDY_TIMEOUT + 1);
    localparam int unsigned LCNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned BCNT_W = $clog2(LOCK_BLANK + 1);

    state_t             r_state, w_state_nxt;
    drp_req_t           r_req;
    logic [DATA_W-1:0]  r_di, w_di_nxt;
    logic [DCNT_W-1:0]  r_dcnt, w_dcnt_nxt, w_dcnt_inc;
    logic [LCNT_W-1:0]  r_lcnt, w_lcnt_nxt, w_lcnt_inc;
    logic [BCNT_W-1:0]  r_bcnt, w_bcnt_nxt;
    logic               r_den, r_dwe, r_pll_rst, r_ready, r_busy, r_done, r_err;
    logic [ERR_W-1:0]   r_err_code, w_err_code_nxt;
    logic               w_load, w_done_nxt, w_err_nxt;
    logic               w_locked_s;
    logic               w_dcnt_expired, w_lcnt_expired;

    sync_2ff u_lock_sync (
        .i_clk (clk100),
        .i_rst (cpu_reset),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    // Saturating counters and their expiry flags
    assign w_dcnt_inc     = (r_dcnt == DCNT_W'(DRDY_TIMEOUT)) ? r_dcnt : r_dcnt + DCNT_W'(1);
    assign w_lcnt_inc     = (r_lcnt == LCNT_W'(LOCK_TIMEOUT)) ? r_lcnt : r_lcnt + LCNT_W'(1);
    assign w_dcnt_expired = (r_dcnt >= DCNT_W'(DRDY_TIMEOUT));
    assign w_lcnt_expired = (r_lcnt >= LCNT_W'(LOCK_TIMEOUT));

    // State register
    always_ff @(posedge clk100) begin
        if (cpu_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and status decode
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_di_nxt       = r_di;
        w_dcnt_nxt     = r_dcnt;
        w_lcnt_nxt     = r_lcnt;
        w_bcnt_nxt     = r_bcnt;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
        w_err_code_nxt = r_err_code;
        case (r_state)
            IDLE, NEXT: begin
                if (req_valid) begin
                    w_load         = 1'b1;
                    w_err_nxt      = 1'b0;
                    w_err_code_nxt = ERR_NONE;
                    w_state_nxt    = READ;
                end
            end
            READ: begin
                w_dcnt_nxt  = DCNT_W'(1);
                w_state_nxt = WAIT_RD;
            end
            WAIT_RD: begin
                w_dcnt_nxt = w_dcnt_inc;
                if (drp_drdy) begin
                    w_di_nxt    = drp_merge(drp_do, r_req.data, r_req.mask);
                    w_state_nxt = WRITE;
                end else if (w_dcnt_expired) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = ERR_DRDY;
                    w_state_nxt    = IDLE;
                end
            end
            WRITE: begin
                w_dcnt_nxt  = DCNT_W'(1);
                w_state_nxt = WAIT_WR;
            end
            WAIT_WR: begin
                w_dcnt_nxt = w_dcnt_inc;
                if (drp_drdy) begin
                    w_state_nxt = r_req.last ? RELEASE : NEXT;
                end else if (w_dcnt_expired) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = ERR_DRDY;
                    w_state_nxt    = IDLE;
                end
            end
            RELEASE: begin
                w_bcnt_nxt  = BCNT_W'(LOCK_BLANK);
                w_lcnt_nxt  = LCNT_W'(1);
                w_state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                w_lcnt_nxt = w_lcnt_inc;
                if (r_bcnt != '0) begin
                    w_bcnt_nxt = r_bcnt - BCNT_W'(1);
                end
                if ((r_bcnt == '0) && w_locked_s) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_lcnt_expired) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = ERR_LOCK;
                    w_state_nxt    = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch, counters and registered outputs decoded from the next state
    always_ff @(posedge clk100) begin
        if (cpu_reset) begin
            r_req      <= '0;
            r_di       <= '0;
            r_dcnt     <= '0;
            r_lcnt     <= '0;
            r_bcnt     <= '0;
            r_den      <= 1'b0;
            r_dwe      <= 1'b0;
            r_pll_rst  <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            if (w_load) begin
                r_req.addr <= req_addr;
                r_req.data <= req_data;
                r_req.mask <= req_mask;
                r_req.last <= req_last;
            end
            r_di       <= w_di_nxt;
            r_dcnt     <= w_dcnt_nxt;
            r_lcnt     <= w_lcnt_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_den      <= (w_state_nxt == READ) || (w_state_nxt == WRITE);
            r_dwe      <= (w_state_nxt == WRITE);
            r_pll_rst  <= w_state_nxt inside {READ, WAIT_RD, WRITE, WAIT_WR, NEXT, RELEASE};
            r_ready    <= (w_state_nxt == IDLE) || (w_state_nxt == NEXT);
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    assign req_ready = r_ready;
    assign drp_daddr = r_req.addr;
    assign drp_di    = r_di;
    assign drp_den   = r_den;
    assign drp_dwe   = r_dwe;
    assign pll_rst   = r_pll_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_pll_drp_writer.sv
// Directed bench for pll_drp_writer with a DRP responder and PLL lock stimulus.
module tb_pll_drp_writer;

    logic        clk100 = 1'b0;
    logic        cpu_reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_addr = '0;
    logic [15:0] req_data = '0;
    logic [15:0] req_mask = '0;
    logic        req_last = 1'b0;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic        pll_locked = 1'b0;
    logic        pll_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_errors = 0;

    // Responder controls
    logic        resp_rd_en = 1'b1;
    logic        resp_wr_en = 1'b1;
    int          resp_lat = 3;
    logic [15:0] resp_do = 16'h0000;
    int          pend = 0;

    // Monitor state
    int          den_cnt = 0;
    int          dwe_cnt = 0;
    int          b2b_cnt = 0;
    int          done_cnt = 0;
    int          gap_cnt = 0;
    logic        prev_den = 1'b0;
    logic [15:0] wr_di [0:31];
    logic [6:0]  wr_addr [0:31];

    pll_drp_writer #(
        .DRDY_TIMEOUT (64),
        .LOCK_TIMEOUT (100),
        .LOCK_BLANK   (4)
    ) dut (
        .clk100     (clk100),
        .cpu_reset  (cpu_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_mask   (req_mask),
        .req_last   (req_last),
        .drp_daddr  (drp_daddr),
        .drp_di     (drp_di),
        .drp_den    (drp_den),
        .drp_dwe    (drp_dwe),
        .drp_do     (drp_do),
        .drp_drdy   (drp_drdy),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk100 = ~clk100;

    // DRP responder: drdy (with DO) resp_lat cycles after a served DEN
    always @(negedge clk100) begin
        drp_drdy = 1'b0;
        if (drp_den === 1'b1 && (drp_dwe ? resp_wr_en : resp_rd_en)) begin
            pend = resp_lat;
        end else if (pend != 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                drp_drdy = 1'b1;
                drp_do   = resp_do;
            end
        end
    end

    // Observe DRP pulses, write log, done pulses and NEXT gaps
    always @(negedge clk100) begin
        if (drp_den === 1'b1) begin
            den_cnt = den_cnt + 1;
            if (prev_den) b2b_cnt = b2b_cnt + 1;
            if (drp_dwe === 1'b1) begin
                if (dwe_cnt < 32) begin
                    wr_di[dwe_cnt]   = drp_di;
                    wr_addr[dwe_cnt] = drp_daddr;
                end
                dwe_cnt = dwe_cnt + 1;
            end
        end
        prev_den = (drp_den === 1'b1);
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (req_ready === 1'b1 && busy === 1'b1) gap_cnt = gap_cnt + 1;
    end

    task automatic tick();
        @(negedge clk100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rst_low(input int max, output int n);
        n = 0;
        while (pll_rst !== 1'b0 && n < max) begin tick(); n++; end
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (done !== 1'b1 && n < max) begin tick(); n++; end
    endtask

    task automatic wait_err(input int max, output int n);
        n = 0;
        while (err !== 1'b1 && n < max) begin tick(); n++; end
    endtask

    task automatic wait_ready(input int max, output int n);
        n = 0;
        while (req_ready !== 1'b1 && n < max) begin tick(); n++; end
    endtask

    // Present a request, wait for acceptance, then check the READ cycle (accept+1)
    task automatic send_req(input string tag, input logic [6:0] a, input logic [15:0] d,
                            input logic [15:0] m, input logic l);
        int n;
        req_addr  = a;
        req_data  = d;
        req_mask  = m;
        req_last  = l;
        req_valid = 1'b1;
        wait_ready(300, n);
        chk({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, "_den"}, 32'(drp_den), 32'd1);
        chk({tag, "_dwe"}, 32'(drp_dwe), 32'd0);
        chk({tag, "_daddr"}, 32'(drp_daddr), 32'(a));
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, "_ready_low"}, 32'(req_ready), 32'd0);
        chk({tag, "_err_clr"}, 32'({err, err_code}), 32'd0);
    endtask

    initial begin
        int n;
        int done0;
        int den0;
        int dwe0;
        int gap0;

        // Reset values
        repeat (3) tick();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_den", 32'({drp_den, drp_dwe}), 32'd0);
        chk("rst_daddr", 32'(drp_daddr), 32'd0);
        chk("rst_di", 32'(drp_di), 32'd0);
        chk("rst_pll_rst", 32'(pll_rst), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        chk("rst_err", 32'({err, err_code}), 32'd0);
        cpu_reset = 1'b0;
        tick();

        // Single update: A555 & F000 | 1041 & 0FFF = A041
        resp_do = 16'hA555;
        done0 = done_cnt; den0 = den_cnt; dwe0 = dwe_cnt;
        send_req("single", 7'h08, 16'h1041, 16'hF000, 1'b1);
        wait_rst_low(50, n);
        chk("single_rst_hi_cycles", 32'(n), 32'd9);
        chk("single_wr_di", 32'(wr_di[dwe0]), 32'h0000A041);
        chk("single_wr_addr", 32'(wr_addr[dwe0]), 32'h08);
        chk("single_den_cnt", 32'(den_cnt - den0), 32'd2);
        chk("single_busy_lockwait", 32'(busy), 32'd1);
        repeat (19) tick();
        pll_locked = 1'b1;
        wait_done(20, n);
        chk("single_done_latency", 32'(n), 32'd3);
        repeat (3) tick();
        chk("single_done_once", 32'(done_cnt - done0), 32'd1);
        chk("single_idle", 32'({busy, pll_rst, req_ready}), 32'b001);
        chk("single_err", 32'({err, err_code}), 32'd0);

        // Batch of three with NEXT gaps; DO = 5A5A
        resp_do = 16'h5A5A;
        done0 = done_cnt; den0 = den_cnt; dwe0 = dwe_cnt; gap0 = gap_cnt;
        send_req("batch0", 7'h14, 16'h00C3, 16'hFF00, 1'b0);
        wait_ready(50, n);
        chk("batch_gap1_rst", 32'({pll_rst, busy, req_ready}), 32'b111);
        send_req("batch1", 7'h15, 16'hFFFF, 16'h0F0F, 1'b0);
        wait_ready(50, n);
        chk("batch_gap2_rst", 32'({pll_rst, busy, req_ready}), 32'b111);
        send_req("batch2", 7'h16, 16'h0000, 16'h0000, 1'b1);
        wait_rst_low(50, n);
        chk("batch_rst_hi_cycles", 32'(n), 32'd9);
        wait_done(30, n);
        chk("batch_done_latency", 32'(n), 32'd5);
        repeat (3) tick();
        chk("batch_wr0", 32'(wr_di[dwe0]), 32'h00005AC3);
        chk("batch_wr1", 32'(wr_di[dwe0 + 1]), 32'h0000FAFA);
        chk("batch_wr2", 32'(wr_di[dwe0 + 2]), 32'h00000000);
        chk("batch_wr2_addr", 32'(wr_addr[dwe0 + 2]), 32'h16);
        chk("batch_den_cnt", 32'(den_cnt - den0), 32'd6);
        chk("batch_gap_cycles", 32'(gap_cnt - gap0), 32'd2);
        chk("batch_done_once", 32'(done_cnt - done0), 32'd1);

        // DRDY timeout on the read
        resp_rd_en = 1'b0;
        dwe0 = dwe_cnt;
        send_req("drdy_to", 7'h09, 16'h1234, 16'h0000, 1'b1);
        wait_err(100, n);
        chk("drdy_to_cycles", 32'(n), 32'd65);
        chk("drdy_to_code", 32'(err_code), 32'd1);
        chk("drdy_to_state", 32'({pll_rst, busy, req_ready}), 32'b001);
        tick();
        chk("drdy_to_no_dwe", 32'(dwe_cnt - dwe0), 32'd0);
        resp_rd_en = 1'b1;

        // Lock timeout with LOCKED held low
        pll_locked = 1'b0;
        resp_do = 16'h0F0F;
        done0 = done_cnt;
        send_req("lock_to", 7'h16, 16'h0041, 16'hFF00, 1'b1);
        wait_rst_low(50, n);
        chk("lock_to_rst_hi_cycles", 32'(n), 32'd9);
        wait_err(200, n);
        chk("lock_to_cycles", 32'(n), 32'd100);
        chk("lock_to_code", 32'(err_code), 32'd2);
        chk("lock_to_idle", 32'({busy, req_ready}), 32'b01);
        chk("lock_to_no_done", 32'(done_cnt - done0), 32'd0);

        // Stale lock: LOCKED high, drops after release, rises 30 cycles later
        pll_locked = 1'b1;
        repeat (3) tick();
        done0 = done_cnt;
        send_req("stale", 7'h0A, 16'h00FF, 16'hFF00, 1'b1);
        wait_rst_low(50, n);
        tick();
        pll_locked = 1'b0;
        repeat (30) tick();
        chk("stale_no_done_blank", 32'(done_cnt - done0), 32'd0);
        chk("stale_still_waiting", 32'({busy, err}), 32'b10);
        pll_locked = 1'b1;
        wait_done(20, n);
        chk("stale_done_latency", 32'(n), 32'd3);
        repeat (3) tick();
        chk("stale_done_once", 32'(done_cnt - done0), 32'd1);

        // drdy on the final allowed wait cycle counts as success
        resp_lat = 64;
        resp_do = 16'hABCD;
        done0 = done_cnt; dwe0 = dwe_cnt;
        send_req("edge", 7'h28, 16'h0000, 16'hFFFE, 1'b1);
        wait_rst_low(300, n);
        chk("edge_rst_hi_cycles", 32'(n), 32'd131);
        chk("edge_wr_di", 32'(wr_di[dwe0]), 32'h0000ABCC);
        wait_done(30, n);
        chk("edge_done_latency", 32'(n), 32'd5);
        chk("edge_err", 32'({err, err_code}), 32'd0);
        resp_lat = 3;
        tick();

        // cpu_reset during WAIT_WR
        resp_wr_en = 1'b0;
        dwe0 = dwe_cnt;
        send_req("rstww", 7'h4E, 16'h1111, 16'h00FF, 1'b0);
        n = 0;
        while (dwe_cnt == dwe0 && n < 50) begin tick(); n++; end
        chk("rstww_write_seen", 32'(dwe_cnt - dwe0), 32'd1);
        repeat (2) tick();
        chk("rstww_in_wait", 32'({busy, pll_rst, drp_den}), 32'b110);
        cpu_reset = 1'b1;
        tick();
        chk("rstww_outputs", 32'({req_ready, drp_den, drp_dwe, pll_rst, busy, done, err}), 32'b1000000);
        chk("rstww_bus", 32'({drp_daddr, drp_di, err_code}), 32'd0);
        cpu_reset = 1'b0;
        resp_wr_en = 1'b1;
        tick();
        done0 = done_cnt; dwe0 = dwe_cnt;
        resp_do = 16'hC3C3;
        send_req("after_rst", 7'h4F, 16'h0F00, 16'h00FF, 1'b1);
        wait_rst_low(50, n);
        chk("after_rst_hi_cycles", 32'(n), 32'd9);
        chk("after_rst_wr_di", 32'(wr_di[dwe0]), 32'h00000FC3);
        wait_done(30, n);
        chk("after_rst_done_latency", 32'(n), 32'd5);
        repeat (3) tick();
        chk("after_rst_done_once", 32'(done_cnt - done0), 32'd1);
        chk("after_rst_err", 32'({err, err_code}), 32'd0);

        chk("den_never_b2b", 32'(b2b_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
